// File: rtl/serial_word_rx.sv
// serial_word_rx: deserializer for an LSB-first framed serial stream.
// Frame (in sample order): start(1), WIDTH data bits, optional even-parity
// bit, stop(0). Received words are held in a one-entry valid/ready buffer.
module serial_word_rx #(
    parameter int WIDTH     = 32,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inb,
    input  logic             bit_en,
    input  logic             clr_err,
    output logic [WIDTH-1:0] word,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             parity_err,
    output logic             frame_err,
    output logic             overrun,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] shift_reg;
    logic             par_acc;
    logic             par_mis;
    logic             frame_done;
    logic             buf_load;

    // Stop sample closes the frame; it is accepted only if the buffer is free
    // or being emptied in this same cycle.
    assign frame_done = (state == ST_STOP) && bit_en;
    assign buf_load   = frame_done && (!word_valid || word_ready);
    assign busy       = (state != ST_IDLE);

    // Frame FSM, bit counter, shift register and parity accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
            par_acc   <= 1'b0;
            par_mis   <= 1'b0;
        end else if (bit_en) begin
            case (state)
                ST_IDLE: begin
                    if (inb) begin
                        state   <= ST_DATA;
                        bit_cnt <= '0;
                        par_acc <= 1'b0;
                        par_mis <= 1'b0;
                    end
                end
                ST_DATA: begin
                    // New bit enters at the MSB so the first bit ends up in bit 0.
                    shift_reg <= {inb, shift_reg[WIDTH-1:1]};
                    bit_cnt   <= bit_cnt + CNT_W'(1);
                    par_acc   <= par_acc ^ inb;
                    if (bit_cnt == CNT_W'(WIDTH - 1)) begin
                        state <= PARITY_EN ? ST_PARITY : ST_STOP;
                    end
                end
                ST_PARITY: begin
                    // Even parity: data ones plus parity bit must be even.
                    par_mis <= par_acc ^ inb;
                    state   <= ST_STOP;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Output buffer with valid/ready handshake and sticky overrun flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word       <= '0;
            word_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (buf_load) begin
                word       <= shift_reg;
                parity_err <= PARITY_EN ? par_mis : 1'b0;
                frame_err  <= inb;
                word_valid <= 1'b1;
            end else if (word_valid && word_ready) begin
                word_valid <= 1'b0;
            end
            // A dropped frame outranks a simultaneous clear.
            if (frame_done && !buf_load) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_word_rx.sv
// Bench for serial_word_rx (WIDTH=8, PARITY_EN=1): directed scenarios plus
// randomized frames checked against a frame-level reference model.
module tb_serial_word_rx;

    logic       clk;
    logic       rst;
    logic       inb;
    logic       bit_en;
    logic       clr_err;
    logic [7:0] word;
    logic       word_valid;
    logic       word_ready;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int errors;
    int checks;
    bit track_drop;
    bit valid_dropped;

    serial_word_rx #(.WIDTH(8), .PARITY_EN(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .inb        (inb),
        .bit_en     (bit_en),
        .clr_err    (clr_err),
        .word       (word),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watches word_valid for a gap while a back-to-back handover is tracked.
    always @(negedge clk) begin
        if (track_drop && !word_valid) valid_dropped = 1'b1;
    end

    // Reference model: parity mismatch for an even-parity frame.
    function automatic bit ref_par_err(input logic [7:0] d, input bit p);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += d[i];
        ones += p;
        return (ones % 2) != 0;
    endfunction

    function automatic bit good_parity(input logic [7:0] d);
        return ref_par_err(d, 1'b0);
    endfunction

    // One clock: apply inputs, wait for the edge, settle 1 time unit.
    task automatic cyc(input bit b, input bit en, input bit rdy);
        inb        = b;
        bit_en     = en;
        word_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    // Send one frame. gap_mode: 0 none, 1 one garbage cycle after each
    // sample, 2 random 0..2 garbage cycles after each sample except the last.
    task automatic send_frame(input logic [7:0] d, input bit p, input bit s,
                              input bit rdy_last, input int gap_mode);
        bit smp [11];
        int gaps;
        smp[0] = 1'b1;
        for (int i = 0; i < 8; i++) smp[i+1] = d[i];
        smp[9]  = p;
        smp[10] = s;
        for (int i = 0; i < 11; i++) begin
            cyc(smp[i], 1'b1, (i == 10) ? rdy_last : 1'b0);
            gaps = (gap_mode == 1) ? 1 :
                   (gap_mode == 2 && i != 10) ? int'($urandom_range(0, 2)) : 0;
            for (int g = 0; g < gaps; g++) cyc(1'($urandom), 1'b0, 1'b0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; inb = 1'b0; bit_en = 1'b0; clr_err = 1'b0; word_ready = 1'b0;
        track_drop = 1'b0; valid_dropped = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({word, word_valid, parity_err, frame_err, overrun, busy} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs: got word=%h v=%b pe=%b fe=%b ov=%b busy=%b, want all 0",
                     word, word_valid, parity_err, frame_err, overrun, busy);
        end
        rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_basic();
        logic [10:0] fr;
        fr = {1'b0, 1'b0, 8'hA5, 1'b1};
        for (int i = 0; i < 10; i++) cyc(fr[i], 1'b1, 1'b0);
        checks++;
        if (word_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_pre_stop: got v=%b busy=%b, want v=0 busy=1", word_valid, busy);
        end
        cyc(fr[10], 1'b1, 1'b0);
        checks++;
        if (word_valid !== 1'b1 || word !== 8'hA5 || parity_err !== 1'b0 ||
            frame_err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_word: got v=%b w=%h pe=%b fe=%b busy=%b, want v=1 w=a5 pe=0 fe=0 busy=0",
                     word_valid, word, parity_err, frame_err, busy);
        end
        cyc(1'b0, 1'b0, 1'b0);
        checks++;
        if (word_valid !== 1'b1 || word !== 8'hA5) begin
            errors++;
            $display("FAIL basic_hold: got v=%b w=%h, want v=1 w=a5", word_valid, word);
        end
        cyc(1'b0, 1'b0, 1'b1);
        checks++;
        if (word_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_consume: got v=%b, want 0", word_valid);
        end
    endtask

    task automatic test_errors();
        logic [10:0] fr;
        fr = {1'b1, 1'b1, 8'hA5, 1'b1};
        for (int i = 0; i < 11; i++) cyc(fr[i], 1'b1, 1'b1);
        checks++;
        if (word_valid !== 1'b1 || word !== 8'hA5 || parity_err !== 1'b1 || frame_err !== 1'b1) begin
            errors++;
            $display("FAIL err_flags: got v=%b w=%h pe=%b fe=%b, want v=1 w=a5 pe=1 fe=1",
                     word_valid, word, parity_err, frame_err);
        end
        cyc(1'b0, 1'b0, 1'b1);
        checks++;
        if (word_valid !== 1'b0) begin
            errors++;
            $display("FAIL err_one_cycle: got v=%b, want 0", word_valid);
        end
    endtask

    task automatic test_bit_en();
        int cycles;
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_zeros: got busy=%b, want 0", busy);
        end
        cycles = 0;
        for (int i = 0; i < 11; i++) begin
            logic [10:0] fr;
            fr = {1'b0, good_parity(8'h3C), 8'h3C, 1'b1};
            cyc(fr[i], 1'b1, 1'b0);
            cycles++;
            if (i == 10) break;
            cyc(1'($urandom), 1'b0, 1'b0);
            cycles++;
        end
        checks++;
        if (word_valid !== 1'b1 || word !== 8'h3C || parity_err !== 1'b0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL bit_en_word: got v=%b w=%h pe=%b fe=%b, want v=1 w=3c pe=0 fe=0",
                     word_valid, word, parity_err, frame_err);
        end
        cyc(1'($urandom), 1'b0, 1'b1);
        cycles++;
        checks++;
        if (cycles != 22) begin
            errors++;
            $display("FAIL bit_en_cycles: got %0d, want 22", cycles);
        end
    endtask

    task automatic test_overrun();
        send_frame(8'h01, good_parity(8'h01), 1'b0, 1'b0, 0);
        send_frame(8'hFF, good_parity(8'hFF), 1'b0, 1'b0, 0);
        checks++;
        if (word_valid !== 1'b1 || word !== 8'h01 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set: got v=%b w=%h ov=%b, want v=1 w=01 ov=1",
                     word_valid, word, overrun);
        end
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        checks++;
        if (word_valid !== 1'b0 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_drain: got v=%b ov=%b, want v=0 ov=1", word_valid, overrun);
        end
        clr_err = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        clr_err = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clear: got ov=%b, want 0", overrun);
        end
    endtask

    task automatic test_back_to_back();
        send_frame(8'h12, good_parity(8'h12), 1'b0, 1'b0, 0);
        valid_dropped = 1'b0;
        track_drop    = 1'b1;
        send_frame(8'h34, good_parity(8'h34), 1'b0, 1'b1, 0);
        track_drop    = 1'b0;
        checks++;
        if (word_valid !== 1'b1 || word !== 8'h34 || valid_dropped || overrun !== 1'b0) begin
            errors++;
            $display("FAIL b2b_handover: got v=%b w=%h gap=%b ov=%b, want v=1 w=34 gap=0 ov=0",
                     word_valid, word, valid_dropped, overrun);
        end
        cyc(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        d = 8'h5A;
        cyc(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cyc(d[i], 1'b1, 1'b0);
        rst = 1'b1;
        #2;
        checks++;
        if ({word, word_valid, parity_err, frame_err, overrun, busy} !== 13'd0) begin
            errors++;
            $display("FAIL reset_async: got w=%h v=%b pe=%b fe=%b ov=%b busy=%b, want all 0",
                     word, word_valid, parity_err, frame_err, overrun, busy);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
        checks++;
        if (word_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_partial: got v=%b busy=%b, want 0 0", word_valid, busy);
        end
        send_frame(d, good_parity(d), 1'b0, 1'b0, 0);
        checks++;
        if (word_valid !== 1'b1 || word !== 8'h5A || parity_err !== 1'b0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_next_frame: got v=%b w=%h pe=%b fe=%b, want v=1 w=5a pe=0 fe=0",
                     word_valid, word, parity_err, frame_err);
        end
        cyc(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        logic [7:0] d;
        bit p, s;
        int idle;
        for (int n = 0; n < 24; n++) begin
            d    = 8'($urandom);
            p    = 1'($urandom);
            s    = ($urandom_range(0, 3) == 0);
            idle = $urandom_range(0, 3);
            for (int k = 0; k < idle; k++) cyc(1'b0, 1'($urandom), 1'b0);
            send_frame(d, p, s, 1'b0, 2);
            checks++;
            if (word_valid !== 1'b1 || word !== d || parity_err !== ref_par_err(d, p) ||
                frame_err !== s || overrun !== 1'b0) begin
                errors++;
                $display("FAIL rand_frame%0d: got v=%b w=%h pe=%b fe=%b ov=%b, want v=1 w=%h pe=%b fe=%b ov=0",
                         n, word_valid, word, parity_err, frame_err, overrun, d, ref_par_err(d, p), s);
            end
            cyc(1'b0, 1'b0, 1'b1);
            checks++;
            if (word_valid !== 1'b0) begin
                errors++;
                $display("FAIL rand_consume%0d: got v=%b, want 0", n, word_valid);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_basic();
        test_errors();
        test_bit_en();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
